// File: rtl/scale_addr_gen.sv
// scale_addr_gen: walks the output raster, emitting clamped frame-buffer read addresses and phases.
// Define SCALE_HMIRROR_EN to mirror columns horizontally.
module scale_addr_gen #(
  parameter int X_SIZE = 960,
  parameter int Y_SIZE = 1080,
  parameter int ADDR_W = 21
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [19:0]       x_add,
  input  logic [19:0]       y_add,
  input  logic [12:0]       x_rd_size,
  input  logic [12:0]       y_rd_size,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        x_frac,
  output logic [7:0]        y_frac,
  output logic              line_end,
  output logic              frame_end,
  output logic              busy
);
  localparam logic [11:0] X_MAX = 12'(X_SIZE - 1);
  localparam logic [11:0] Y_MAX = 12'(Y_SIZE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [19:0] x_add_l, y_add_l, x_acc, y_acc;
  logic [12:0] xs_l, ys_l, x_cnt, y_cnt;
  logic [20:0] x_sum, y_sum;
  logic [11:0] x_clamp, x_int, y_int, s1_x, s1_y;
  logic [7:0]  s1_xf, s1_yf;
  logic        s1_v, s1_le, s1_last, s2_last;
  logic        adv, accept, start, issue, x_wrap, last_px;
  assign adv = !rd_valid || rd_ready;
  assign accept = rd_valid && rd_ready;
  assign start = state == IDLE && frame_start && x_rd_size != '0 && y_rd_size != '0;
  assign issue = state == RUN && adv;
  assign x_wrap = x_cnt == xs_l - 13'd1;
  assign last_px = x_wrap && y_cnt == ys_l - 13'd1;
  assign x_sum = {1'b0, x_acc} + {1'b0, x_add_l};
  assign y_sum = {1'b0, y_acc} + {1'b0, y_add_l};
  assign x_clamp = x_acc[19:8] > X_MAX ? X_MAX : x_acc[19:8];
  assign y_int = y_acc[19:8] > Y_MAX ? Y_MAX : y_acc[19:8];
`ifdef SCALE_HMIRROR_EN
  assign x_int = X_MAX - x_clamp;
`else
  assign x_int = x_clamp;
`endif
  assign frame_end = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (start) state_n = RUN;
    else if (issue && last_px) state_n = DRAIN;
    else if (state == DRAIN && accept && s2_last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge rd_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge rd_clk or posedge rst)
    if (rst) begin
      x_add_l <= '0;
      y_add_l <= '0;
      xs_l <= '0;
      ys_l <= '0;
      x_acc <= '0;
      y_acc <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      s1_xf <= '0;
      s1_yf <= '0;
      s1_le <= 1'b0;
      s1_last <= 1'b0;
      rd_valid <= 1'b0;
      rd_addr <= '0;
      x_frac <= '0;
      y_frac <= '0;
      line_end <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      if (start) begin
        x_add_l <= x_add;
        y_add_l <= y_add;
        xs_l <= x_rd_size;
        ys_l <= y_rd_size;
        x_acc <= '0;
        y_acc <= '0;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        // accumulators saturate instead of wrapping so huge steps still clamp to the frame edge
        x_acc <= x_wrap ? '0 : x_sum[20] ? 20'hFFFFF : x_sum[19:0];
        x_cnt <= x_wrap ? '0 : x_cnt + 13'd1;
        if (x_wrap) begin
          y_acc <= y_sum[20] ? 20'hFFFFF : y_sum[19:0];
          y_cnt <= y_cnt + 13'd1;
        end
      end
      if (issue) begin
        s1_v <= 1'b1;
        s1_x <= x_int;
        s1_y <= y_int;
        s1_xf <= x_acc[7:0];
        s1_yf <= y_acc[7:0];
        s1_le <= x_wrap;
        s1_last <= last_px;
      end else if (adv) s1_v <= 1'b0;
      if (adv) begin
        rd_valid <= s1_v;
        rd_addr <= ADDR_W'(32'(s1_y) * 32'(X_SIZE) + 32'(s1_x));
        x_frac <= s1_xf;
        y_frac <= s1_yf;
        line_end <= s1_le;
        s2_last <= s1_last;
      end
    end
endmodule
